fb_port_arbiter: RTL and testbench

- Shares one single-port frame-buffer BRAM (640x480 pixels, 12-bit RGB444) between two requesters:
  - the camera pixel writer, which cannot be stalled;
  - the VGA pixel reader, which has a hard per-pixel deadline.
- VGA reads always win the port. Camera writes are buffered in a small FIFO and retired in cycles the reader leaves free.
- Also implements the freeze-frame function: when pause is asserted, already-buffered writes drain, then the image freezes.

---
 rtl/fb_port_arbiter_pkg.sv | 15 +
 rtl/fb_wr_fifo.sv | 49 ++++
 rtl/fb_port_arbiter.sv | 137 +++++++++++++
 tb/tb_fb_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_port_arbiter_pkg.sv
// Shared frame-buffer constants and arbiter state encoding.
package fb_port_arbiter_pkg;

    localparam int unsigned FB_W        = 640;
    localparam int unsigned FB_H        = 480;
    localparam int unsigned FB_PIXELS   = FB_W * FB_H;
    localparam int unsigned DRAIN_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Camera write buffer: synchronous FIFO with same-cycle push and pop.
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads win, camera writes are
// buffered and retired in free slots; pause drains then freezes the image.
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         pause,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_din,
    input  logic [DATA_W-1:0]            mem_dout,
    output logic                         frozen,
    output logic [DRAIN_CNT_W-1:0]       drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int unsigned ENT_W = ADDR_W + DATA_W;
    localparam logic [DRAIN_CNT_W-1:0] DROP_MAX = '1;

    fb_state_e         state;
    fb_state_e         state_nxt;
    logic              fifo_push_c;
    logic              fifo_pop_c;
    logic              drop_c;
    logic              frozen_nxt_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_head;
    logic [RD_LAT-1:0] rd_pipe;

    fb_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .din   ({wr_addr, wr_data}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:    if (pause) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!pause)                          state_nxt = ST_RUN;
                else if (fifo_empty && !fifo_push_c) state_nxt = ST_FROZEN;
            end
            ST_FROZEN: if (!pause) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // A full FIFO still accepts a pixel when the head retires the same cycle.
    always_comb begin
        fifo_pop_c   = 1'b0;
        fifo_push_c  = 1'b0;
        drop_c       = 1'b0;
        frozen_nxt_c = 1'b0;
        fifo_pop_c   = !rd_req && !fifo_empty && (state != ST_FROZEN);
        if (state == ST_RUN && wr_valid) begin
            if (!fifo_full || fifo_pop_c) fifo_push_c = 1'b1;
            else                          drop_c      = 1'b1;
        end
        frozen_nxt_c = (state_nxt == ST_FROZEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (rd_req) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
        end else if (fifo_pop_c) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= fifo_head[ENT_W-1 -: ADDR_W];
            mem_din  <= fifo_head[DATA_W-1:0];
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
        end
    end

    // Read-valid pipe: issue stage, RD_LAT-1 BRAM stages, then capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pipe  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe[0] <= rd_req;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            rd_valid <= rd_pipe[RD_LAT-1];
            if (rd_pipe[RD_LAT-1]) rd_data <= mem_dout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            frozen   <= 1'b0;
        end else begin
            if (drop_c && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DRAIN_CNT_W'(1);
            frozen <= frozen_nxt_c;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus random traffic against
// a queue-based reference model of the shared frame-buffer port.
module tb_fb_port_arbiter;

    typedef struct packed {
        logic [18:0] a;
        logic [11:0] d;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        pause;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [11:0] mem_din;
    logic [11:0] mem_dout;
    logic        frozen;
    logic [15:0] drop_cnt;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    fb_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pause      (pause),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .frozen     (frozen),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] init_val(input logic [18:0] a);
        return 12'(a) ^ 12'hBBC;
    endfunction

    // BRAM model: unwritten words read back init_val; data appears one
    // clock after the read is presented, so it is sampled RD_LAT=2 edges after issue.
    bit [11:0]   bram_d [2**19];
    bit          bram_w [2**19];
    logic [11:0] dout_q = '0;
    always @(posedge clk) begin
        if (mem_en && !mem_we) dout_q <= bram_w[mem_addr] ? bram_d[mem_addr] : init_val(mem_addr);
        if (mem_en && mem_we) begin
            bram_d[mem_addr] <= mem_din;
            bram_w[mem_addr] <= 1'b1;
        end
    end
    assign mem_dout = dout_q;

    // Reference model state
    ent_t        q[$];
    int          mode;
    int          drops;
    bit [11:0]   sh_d [2**19];
    bit          sh_w [2**19];
    logic        e_en, e_we, p0v, p1v;
    logic [18:0] e_addr;
    logic [11:0] e_din, e_rd, p0d, p1d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = 0; drops = 0;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0; e_rd = '0;
        p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0;
    endtask

    // Advance one clock, predicting every output from the spec rules.
    task automatic cycle();
        int          sz;
        bit          iss;
        logic [11:0] snap;
        logic        ev;
        ent_t        ent;
        sz = q.size(); iss = 1'b0; snap = '0;
        if (rd_req) begin
            e_en = 1'b1; e_we = 1'b0; e_addr = rd_addr; iss = 1'b1;
            snap = sh_w[rd_addr] ? sh_d[rd_addr] : init_val(rd_addr);
        end else if (sz > 0 && mode != 2) begin
            ent = q.pop_front();
            e_en = 1'b1; e_we = 1'b1; e_addr = ent.a; e_din = ent.d;
            sh_d[ent.a] = ent.d; sh_w[ent.a] = 1'b1;
        end else begin
            e_en = 1'b0; e_we = 1'b0;
        end
        if (mode == 0 && wr_valid) begin
            if (q.size() < 8) q.push_back('{a: wr_addr, d: wr_data});
            else if (drops < 65535) drops++;
        end
        case (mode)
            0: if (pause) mode = 1;
            1: if (!pause) mode = 0; else if (sz == 0) mode = 2;
            2: if (!pause) mode = 0;
            default: mode = 0;
        endcase
        ev = p1v;
        if (p1v) e_rd = p1d;
        p1v = p0v; p1d = p0d; p0v = iss; p0d = snap;
        @(posedge clk); #1;
        check("mem_en", 32'(mem_en), 32'(e_en));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_din", 32'(mem_din), 32'(e_din));
        check("rd_valid", 32'(rd_valid), 32'(ev));
        check("rd_data", 32'(rd_data), 32'(e_rd));
        check("frozen", 32'(frozen), 32'(mode == 2));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("drop_cnt", 32'(drop_cnt), 32'(drops));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        pause = 1'b0; rd_req = 1'b0; rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_frozen", 32'(frozen), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        rst = 1'b1;
        cycle();

        // Read latency
        rd_req = 1'b1; rd_addr = 19'h00100; cycle();
        rd_req = 1'b0; cycle(); cycle();
        check("lat_rd_valid", 32'(rd_valid), 32'd1);
        check("lat_rd_data", 32'(rd_data), 32'hABC);

        // Write held behind a 10-cycle read burst
        rd_req = 1'b1; rd_addr = 19'h00020;
        wr_valid = 1'b1; wr_addr = 19'h00005; wr_data = 12'h123; cycle();
        wr_valid = 1'b0;
        repeat (9) cycle();
        rd_req = 1'b0; cycle();
        check("wbr_mem_we", 32'(mem_we), 32'd1);
        check("wbr_mem_addr", 32'(mem_addr), 32'h00005);
        check("wbr_mem_din", 32'(mem_din), 32'h123);
        check("wbr_fifo_level", 32'(fifo_level), 32'd0);

        // Overflow under continuous reads
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(32'h10 + i); wr_data = 12'($urandom); cycle();
        end
        wr_valid = 1'b0; cycle();
        check("ovf_fifo_level", 32'(fifo_level), 32'd8);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        rd_req = 1'b0;
        repeat (10) cycle();

        // Pause: drain three entries, freeze, reads continue, resume
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(32'h30 + i); wr_data = 12'($urandom); cycle();
        end
        wr_valid = 1'b0; rd_req = 1'b0; pause = 1'b1;
        repeat (5) cycle();
        check("pz_frozen", 32'(frozen), 32'd1);
        check("pz_fifo_level", 32'(fifo_level), 32'd0);
        wr_valid = 1'b1; wr_addr = 19'h00031; wr_data = 12'hFFF;
        repeat (3) cycle();
        wr_valid = 1'b0;
        check("pz_drop_cnt", 32'(drop_cnt), 32'd2);
        rd_req = 1'b1; rd_addr = 19'h00031; cycle();
        rd_req = 1'b0; repeat (3) cycle();
        pause = 1'b0; cycle();
        check("pz_unfrozen", 32'(frozen), 32'd0);
        wr_valid = 1'b1; wr_addr = 19'h00032; wr_data = 12'h456; cycle();
        wr_valid = 1'b0; cycle();
        check("pz_resume_we", 32'(mem_we), 32'd1);

        // Full FIFO with simultaneous push and pop
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(32'h40 + i); wr_data = 12'($urandom); cycle();
        end
        rd_req = 1'b0; wr_valid = 1'b1; wr_addr = 19'h00048; wr_data = 12'h789; cycle();
        wr_valid = 1'b0;
        check("full_pp_level", 32'(fifo_level), 32'd8);
        check("full_pp_drop", 32'(drop_cnt), 32'd2);
        check("full_pp_we", 32'(mem_we), 32'd1);
        repeat (10) cycle();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rd_req   = ($urandom_range(0, 99) < 45);
            rd_addr  = 19'($urandom_range(0, 63));
            wr_valid = ($urandom_range(0, 99) < 60);
            wr_addr  = 19'($urandom_range(0, 63));
            wr_data  = 12'($urandom);
            if ($urandom_range(0, 99) < 3) pause = !pause;
            cycle();
        end
        pause = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
        repeat (12) cycle();

        // Reset with buffered writes and a read in flight
        rd_req = 1'b1; rd_addr = 19'h00100;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(32'h50 + i); wr_data = 12'($urandom); cycle();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        rst = 1'b0;
        #1;
        check("mrst_mem_en", 32'(mem_en), 32'd0);
        check("mrst_mem_we", 32'(mem_we), 32'd0);
        check("mrst_fifo_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mrst_rd_valid", 32'(rd_valid), 32'd0);
            check("mrst_mem_en_hold", 32'(mem_en), 32'd0);
        end
        rst = 1'b1;
        model_reset();
        cycle();
        check("mrst_level_after", 32'(fifo_level), 32'd0);
        check("mrst_drop_after", 32'(drop_cnt), 32'd0);
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
